// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant Wishbone UART transmitter.
package servant_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic ADR_TXDATA = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_CNT_W   = 4;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/servant_uart_fifo.sv
// Small synchronous FIFO; a push to a full FIFO is dropped even with a same-edge pop.
module servant_uart_fifo
    import servant_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = BYTE_W
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata_c,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_do_push   = i_push & ~r_full;
    assign w_do_pop    = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge wb_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: bus registers, TX FIFO, framing FSM.
module servant_uart_tx
    import servant_uart_pkg::*;
#(
    parameter int unsigned DIV        = 87,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_txd
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic [BYTE_W-1:0]   r_shift;
    logic [BYTE_W-1:0]   w_shift_nxt;
    logic                r_txd;
    logic                w_txd_nxt;
    logic                r_ack;
    logic [31:0]         r_rdt;
    logic                r_ovf;

    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic [BYTE_W-1:0]   w_rdata;
    logic                w_full;
    logic                w_empty;
    logic [FCW-1:0]      w_count;
    logic [31:0]         w_status;
    logic                w_unused;

    assign w_unused = ^i_wb_dat[31:BYTE_W];

    assign w_req  = i_wb_cyc & ~r_ack;
    assign w_push = w_req & i_wb_we & (i_wb_adr == ADR_TXDATA);

    servant_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wdata   (i_wb_dat[BYTE_W-1:0]),
        .o_rdata_c (w_rdata),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_status                                   = '0;
        w_status[STAT_BUSY]                        = (r_state != IDLE);
        w_status[STAT_FULL]                        = w_full;
        w_status[STAT_EMPTY]                       = w_empty;
        w_status[STAT_OVF]                         = r_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]       = STAT_CNT_W'(w_count);
    end

    // Bus side: one registered ack per request, access lands on the ack edge.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_ack <= 1'b0;
            r_rdt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_rdt <= (w_req & ~i_wb_we & (i_wb_adr == ADR_STATUS)) ? w_status : '0;
            if (w_req & i_wb_we & (i_wb_adr == ADR_STATUS) & i_wb_dat[STAT_OVF])
                r_ovf <= 1'b0;
            if (w_push & w_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Framing: every state lasts DIV cycles, bit boundary when the counter hits 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_txd_nxt   = 1'b1;
        w_bit_end   = (r_cnt == '0);

        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rdata;
                    w_cnt_nxt   = CNT_W'(DIV - 1);
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = CNT_W'(DIV - 1);
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = CNT_W'(DIV - 1);
                    if (r_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_rdata;
                        w_cnt_nxt   = CNT_W'(DIV - 1);
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Line level is registered from the next state so it changes on the transition edge.
        unique case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;
    assign o_txd    = r_txd;

endmodule

// File: doc/servant_uart_tx.md
Name: servant_uart_tx

Overview:
Wishbone-slave 8N1 UART transmitter with a small TX FIFO. It replaces the bit-banged GPIO that currently drives uart_txd in the servant SoC. It sits on the servant peripheral bus, upstream of the top-level uart_txd pin (uo_out[1]). The CPU writes bytes to it instead of toggling q in software.

Parameters:
- DIV, 87, clock cycles per UART bit (10 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2

Ports:
- wb_clk  in  1  system clock
- wb_rst  in  1  synchronous reset, active high
- i_wb_adr  in  1  register select: 0 = TXDATA, 1 = STATUS
- i_wb_dat  in  32  write data
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  bus request (cyc and stb combined, servant style)
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  single-cycle acknowledge
- o_txd  out  1  serial output, idle high

Behaviour:
- Reset (wb_rst high at a clock edge), in the following cycle:
  - o_txd=1, o_wb_ack=0, o_wb_rdt=0
  - FSM=IDLE; FIFO emptied; overflow flag cleared; baud counter and bit index cleared
  - Applies mid-frame too: the frame is aborted and the line returns high immediately.
- Bus:
  - o_wb_ack <= i_wb_cyc & !o_wb_ack. One ack per request, registered.
  - The access takes effect on the same edge that raises ack.
- Write TXDATA: pushes i_wb_dat[7:0].
  - If the FIFO is full (evaluated before any same-edge pop), the byte is dropped and overflow is set (sticky).
  - The write is still acked.
- Write STATUS: i_wb_dat[3]=1 clears overflow; all other bits are ignored.
- Read TXDATA: returns 0.
- Read STATUS: o_wb_rdt = {zeros, count[bits 7:4], overflow[3], empty[2], full[1], busy[0]}.
  - busy = FSM != IDLE.
  - count = FIFO occupancy, 0..FIFO_DEPTH.
  - Read data is registered alongside ack and reflects state before that edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - o_txd=1.
  - If the FIFO is non-empty: pop the head into the shift register, load baud counter = DIV-1, go to START.
- START:
  - o_txd=0 for DIV cycles, then go to DATA with bit index 0.
- DATA:
  - o_txd = shift[0], LSB first.
  - Every DIV cycles: shift right and increment the index.
  - After bit 7 has been held DIV cycles, go to STOP.
- STOP:
  - o_txd=1 for DIV cycles.
  - At expiry, if the FIFO is non-empty: pop, go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Baud counter: counts down from DIV-1 to 0; the bit boundary is at 0; it reloads to DIV-1.
- Latency: a write first presented in cycle 0 to an empty, idle block gives:
  - ack high in cycle 1
  - o_txd low starting cycle 2
- Frame length is exactly 10*DIV cycles.
- Simultaneous push and pop: both are performed when the FIFO is not full, and count is unchanged. A push to a full FIFO is dropped even if a pop occurs on the same edge.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package servant_uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - register address constants ADR_TXDATA=0, ADR_STATUS=1
  - status bit index constants (BUSY=0, FULL=1, EMPTY=2, OVF=3, CNT_LSB=4)
- Sub-module servant_uart_fifo: synchronous FIFO, parameter DEPTH and WIDTH=8.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same wb_clk and synchronous wb_rst.
- The top holds the bus logic, FSM, baud counter and shift register.

Test Plan:
- Single byte, DIV=4: write 0xA5 at cycle 0.
  - Ack in cycle 1; o_txd low cycles 2-5.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles (cycles 6-37).
  - High from cycle 38 onward; busy reads 0 after cycle 41.
- Back-to-back, DIV=4: write 0x00 then 0xFF on consecutive requests.
  - Second start bit begins the cycle after the first stop bit ends; no idle cycles; total 80 cycles of frames.
- Overflow, DIV=16, FIFO_DEPTH=4: six back-to-back writes 0x01..0x06.
  - 0x01 is popped immediately; 0x02-0x05 fill the FIFO; 0x06 is dropped.
  - STATUS reads full=1, overflow=1, count=4.
  - The line carries only 0x01..0x05.
- Overflow clear: write STATUS with 0x8 -> next STATUS read shows overflow=0, other bits unchanged.
- Reset mid-frame: assert wb_rst during DATA bit 3 of 0x3C with two bytes queued.
  - o_txd=1 the next cycle; STATUS reads 0x4 (empty only); no further frames.
- Status idle read after reset: STATUS read returns 0x00000004, TXDATA read returns 0, each with exactly one ack pulse per request.
